// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single multi-cycle main-memory port between the I-cache fill FSM,
// the D-cache fill FSM and the D-cache write-through store path.
//
// The arbiter grants the port to one owner at a time. It multiplexes the
// owner's address, strobe and write data onto the port. It returns
// mem_data_valid to whichever fill owns the port. While reads are still in
// flight, ownership is held, so returning data always reaches the side that
// asked for it.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset (released synchronously)
//   icache_req      in   I-cache fill busy (read request)
//   icache_addr     in   I-cache fill read address
//   dcache_req      in   D-cache fill busy (read request)
//   dcache_addr     in   D-cache fill read address
//   dcache_wr       in   D-cache single-word store request
//   dcache_wr_addr  in   store address
//   dcache_wdata    in   store data
//   mem_data_valid  in   memory read data valid
//   mem_en          out  memory access strobe
//   mem_wr          out  1 = write, 0 = read
//   mem_addr        out  memory address (0 when mem_en = 0)
//   mem_wdata       out  memory write data (0 unless writing)
//   icache_wait     out  I-side requesting but not owner
//   dcache_wait     out  D-side requesting but not owner
//   icache_valid    out  mem_data_valid steered to I-side
//   dcache_valid    out  mem_data_valid steered to D-side
//   arb_error       out  sticky: valid with nothing outstanding, or overflow
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              icache_wait,
    output logic              dcache_wait,
    output logic              icache_valid,
    output logic              dcache_valid,
    output logic              arb_error
);

    localparam int OUT_W = $clog2(MEM_LATENCY + 1) + 1;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MEM_LATENCY);
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [OUT_W-1:0]  outstanding_reg, outstanding_next;
    logic              arb_error_reg, arb_error_next;

    // ------------------------------------------------------------------
    // Reset synchroniser. Assertion reaches the core immediately, and
    // release is aligned to clk. This means no core flop sees reset
    // removal near an edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_reg;
    logic                   rst_core_n;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_rst_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rst_sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    rst_sync_reg[gi] <= 1'b1;
                end else begin
                    rst_sync_reg[gi] <= rst_sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign rst_core_n = rst_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Outstanding-read bookkeeping
    // ------------------------------------------------------------------
    logic rd_issue;
    logic valid_ok;      // a valid that matches a read in flight
    logic inc_ok;        // a read issue that fits in the counter
    logic at_max;
    logic drain_done;    // nothing in flight after this cycle (ignoring new issues)

    assign rd_issue   = mem_en & ~mem_wr;
    assign at_max     = (outstanding_reg == OUT_MAX);
    assign valid_ok   = mem_data_valid & (outstanding_reg != '0);
    assign inc_ok     = rd_issue & (~at_max | valid_ok);
    // Leaving a fill happens only with the owner's request low, so no new
    // read issues that cycle. Only the returning valid can move the count.
    assign drain_done = (outstanding_reg == '0) ||
                        ((outstanding_reg == OUT_W'(1)) && mem_data_valid);

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({inc_ok, valid_ok})
            2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - OUT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    // Stray valids, and issues beyond what the memory can hold, both flag an error.
    // The error stays set until reset.
    always_comb begin
        arb_error_next = arb_error_reg;
        if ((mem_data_valid && (outstanding_reg == '0)) ||
            (rd_issue && at_max && !mem_data_valid)) begin
            arb_error_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and port multiplexing
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_reg)
            IDLE: begin
                // Grant is registered: the winner's first access goes out
                // on the following cycle.
                if (dcache_wr && (outstanding_reg == '0)) begin
                    state_next = D_WRITE;
                end else if (dcache_req) begin
                    state_next = D_FILL;
                end else if (icache_req) begin
                    state_next = I_FILL;
                end
            end

            I_FILL: begin
                mem_en = icache_req;
                if (icache_req) begin
                    mem_addr = icache_addr;
                end
                if (!icache_req && drain_done) begin
                    state_next = IDLE;
                end
            end

            D_FILL: begin
                mem_en = dcache_req;
                if (dcache_req) begin
                    mem_addr = dcache_addr;
                end
                if (!dcache_req && drain_done) begin
                    state_next = IDLE;
                end
            end

            D_WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = dcache_wr_addr;
                mem_wdata  = dcache_wdata;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_reg       <= IDLE;
            outstanding_reg <= '0;
            arb_error_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            arb_error_reg   <= arb_error_next;
        end
    end

    // ------------------------------------------------------------------
    // Side-band outputs
    // ------------------------------------------------------------------
    // The fill state is the latched owner. It persists through the drain,
    // so late data still reaches the side that requested it.
    assign icache_valid = mem_data_valid & (state_reg == I_FILL);
    assign dcache_valid = mem_data_valid & (state_reg == D_FILL);

    // The wait outputs are held low during reset, so every output is quiet
    // while the core is held in reset.
    assign icache_wait = rst_core_n & icache_req & (state_reg != I_FILL);
    assign dcache_wait = rst_core_n & (dcache_req | dcache_wr) &
                         (state_reg != D_FILL) & (state_reg != D_WRITE);

    assign arb_error = arb_error_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        dcache_req;
    logic [15:0] dcache_addr;
    logic        dcache_wr;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wdata;
    logic        mem_data_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        icache_wait;
    logic        dcache_wait;
    logic        icache_valid;
    logic        dcache_valid;
    logic        arb_error;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .dcache_req     (dcache_req),
        .dcache_addr    (dcache_addr),
        .dcache_wr      (dcache_wr),
        .dcache_wr_addr (dcache_wr_addr),
        .dcache_wdata   (dcache_wdata),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .icache_wait    (icache_wait),
        .dcache_wait    (dcache_wait),
        .icache_valid   (icache_valid),
        .dcache_valid   (dcache_valid),
        .arb_error      (arb_error)
    );

    // Memory model: a read strobed in cycle k returns valid in cycle k+4.
    logic [3:0] pipe_reg = 4'b0000;
    logic       mem_mute;
    logic       force_valid;

    always @(posedge clk) pipe_reg <= {pipe_reg[2:0], mem_en & ~mem_wr};
    assign mem_data_valid = (pipe_reg[3] & ~mem_mute) | force_valid;

    // Pulse counters, sampled mid-cycle
    int n_iv = 0;
    int n_dv = 0;
    int n_en = 0;
    always @(negedge clk) begin
        if (icache_valid === 1'b1) n_iv++;
        if (dcache_valid === 1'b1) n_dv++;
        if (mem_en === 1'b1) n_en++;
    end

    int total = 0;
    int bad   = 0;
    int s_iv, s_dv, s_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        icache_req = 1'b1;          // requesting during reset must not show wait
        icache_addr = '0; dcache_req = 1'b0; dcache_addr = '0;
        dcache_wr = 1'b0; dcache_wr_addr = '0; dcache_wdata = '0;
        mem_mute = 1'b0; force_valid = 1'b0;

        repeat (3) nxt();
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_icache_wait", icache_wait, 0);
        chk("rst_arb_error", arb_error, 0);
        $display("txn: reset state checked");

        icache_req = 1'b0;
        rst_n = 1'b1;
        repeat (4) nxt();

        // ---------------- I-only fill: 8 issues, 8 valids ----------------
        s_iv = n_iv; s_dv = n_dv; s_en = n_en;
        icache_req = 1'b1; icache_addr = 16'h1200; #1;                  // cycle A (IDLE)
        chk("i_idle_wait", icache_wait, 1);
        chk("i_idle_en", mem_en, 0);
        for (int k = 0; k < 8; k++) begin                               // A+1..A+8
            nxt();
            icache_addr = 16'h1200 + 16'(2 * k); #1;
            chk("i_fill_en", mem_en, 1);
            chk("i_fill_addr", mem_addr, 16'h1200 + 16'(2 * k));
            chk("i_fill_wait", icache_wait, 0);
        end
        nxt(); icache_req = 1'b0; icache_addr = '0; #1;                 // A+9
        chk("i_drop_en", mem_en, 0);
        chk("i_drop_addr", mem_addr, 0);
        repeat (3) nxt();                                               // A+12
        dcache_req = 1'b1; dcache_addr = 16'h3000; #1;
        chk("i_last_valid", icache_valid, 1);
        chk("i_last_dwait", dcache_wait, 1);
        nxt();                                                          // A+13 IDLE
        icache_req = 1'b1; icache_addr = 16'h1400; #1;
        chk("i_back_idle_en", mem_en, 0);
        chk("both_iwait", icache_wait, 1);
        chk("both_dwait", dcache_wait, 1);
        chk("i_valid_count", n_iv - s_iv, 8);
        chk("i_dvalid_count", n_dv - s_dv, 0);
        chk("i_en_count", n_en - s_en, 8);
        $display("txn: I-only fill of 8 words");

        // ------- both requested in IDLE: D wins, drops with 3 in flight -------
        s_dv = n_dv;
        for (int k = 0; k < 3; k++) begin                               // A+14..A+16
            nxt();
            dcache_addr = 16'h3000 + 16'(2 * k); #1;
            chk("d_fill_en", mem_en, 1);
            chk("d_fill_addr", mem_addr, 16'h3000 + 16'(2 * k));
            chk("d_fill_iwait", icache_wait, 1);
            chk("d_fill_dwait", dcache_wait, 0);
        end
        nxt(); dcache_req = 1'b0; dcache_addr = '0; #1;                 // A+17
        chk("d_drop_en", mem_en, 0);
        chk("d_drop_dvalid", dcache_valid, 0);
        for (int k = 0; k < 3; k++) begin                               // A+18..A+20
            nxt(); #1;
            chk("d_drain_dvalid", dcache_valid, 1);
            chk("d_drain_ivalid", icache_valid, 0);
            chk("d_drain_iwait", icache_wait, 1);
            chk("d_drain_en", mem_en, 0);
        end
        nxt(); #1;                                                      // A+21 IDLE
        chk("d_idle_en", mem_en, 0);
        chk("d_idle_iwait", icache_wait, 1);
        chk("d_valid_count", n_dv - s_dv, 3);
        $display("txn: D fill granted over I, drained 3 in flight");

        // ------- D request arrives mid I fill: no pre-emption -------
        for (int k = 0; k < 4; k++) begin                               // A+22..A+25
            nxt();
            icache_addr = 16'h1400 + 16'(2 * k);
            if (k == 1) begin
                dcache_req = 1'b1; dcache_addr = 16'h5000;
            end
            #1;
            chk("mid_i_en", mem_en, 1);
            chk("mid_i_addr", mem_addr, 16'h1400 + 16'(2 * k));
            chk("mid_i_iwait", icache_wait, 0);
            if (k >= 1) chk("mid_d_wait", dcache_wait, 1);
        end
        for (int k = 0; k < 4; k++) begin                               // A+26..A+29
            nxt();
            if (k == 0) begin
                icache_req = 1'b0; icache_addr = '0;
            end
            #1;
            chk("mid_drain_ivalid", icache_valid, 1);
            chk("mid_drain_dvalid", dcache_valid, 0);
            chk("mid_drain_en", mem_en, 0);
            chk("mid_drain_addr", mem_addr, 0);
            chk("mid_drain_dwait", dcache_wait, 1);
        end
        nxt(); #1;                                                      // A+30 IDLE
        chk("mid_idle_en", mem_en, 0);
        chk("mid_idle_dwait", dcache_wait, 1);
        nxt(); #1;                                                      // A+31 D_FILL
        chk("mid_dgrant_en", mem_en, 1);
        chk("mid_dgrant_addr", mem_addr, 16'h5000);
        chk("mid_dgrant_dwait", dcache_wait, 0);
        nxt(); dcache_req = 1'b0; dcache_addr = '0; #1;
        chk("mid_ddrop_en", mem_en, 0);
        repeat (6) nxt();
        chk("traffic_no_err", arb_error, 0);
        $display("txn: D request held off until I fill drained");

        // ------- store: beats a pending I request -------
        dcache_wr = 1'b1; dcache_wr_addr = 16'h0040; dcache_wdata = 16'hBEEF;
        icache_req = 1'b1; icache_addr = 16'h1600; #1;                  // W (IDLE)
        chk("wr_idle_en", mem_en, 0);
        chk("wr_idle_wdata", mem_wdata, 0);
        chk("wr_idle_dwait", dcache_wait, 1);
        nxt(); #1;                                                      // W+1 D_WRITE
        chk("wr_en", mem_en, 1);
        chk("wr_wr", mem_wr, 1);
        chk("wr_addr", mem_addr, 16'h0040);
        chk("wr_wdata", mem_wdata, 16'hBEEF);
        chk("wr_dwait", dcache_wait, 0);
        chk("wr_iwait", icache_wait, 1);
        nxt(); dcache_wr = 1'b0; icache_req = 1'b0; #1;                 // W+2 IDLE
        chk("wr_after_en", mem_en, 0);
        chk("wr_after_wr", mem_wr, 0);
        chk("wr_after_addr", mem_addr, 0);
        chk("wr_after_wdata", mem_wdata, 0);
        nxt(); #1;
        chk("wr_stay_idle_en", mem_en, 0);
        $display("txn: store 0040 <= BEEF");

        // ------- overflow with a silent memory, then reset mid-fill -------
        mem_mute = 1'b1;
        nxt(); icache_req = 1'b1; icache_addr = 16'h1800; #1;           // R
        for (int k = 0; k < 5; k++) begin                               // R+1..R+5
            nxt(); #1;
            chk("ovf_en", mem_en, 1);
            chk("ovf_err_clear", arb_error, 0);
        end
        nxt(); #1;                                                      // R+6
        chk("ovf_err_set", arb_error, 1);
        rst_n = 1'b0; #1;
        chk("rst_mid_en", mem_en, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_iwait", icache_wait, 0);
        chk("rst_mid_err", arb_error, 0);
        icache_req = 1'b0; icache_addr = '0;
        repeat (2) nxt();
        rst_n = 1'b1;
        repeat (6) nxt();
        mem_mute = 1'b0; #1;
        chk("post_rst_err", arb_error, 0);
        $display("txn: overflow flagged, reset mid-fill");

        // ------- stray valid with nothing in flight -------
        force_valid = 1'b1; #1;
        chk("stray_ivalid", icache_valid, 0);
        chk("stray_dvalid", dcache_valid, 0);
        nxt(); force_valid = 1'b0; #1;
        chk("stray_err", arb_error, 1);
        repeat (2) nxt();
        chk("stray_err_sticky", arb_error, 1);
        $display("txn: stray valid flagged");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
